ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-port external SRAM scheduler for the +3 core. It shares one asynchronous 512 KB SRAM between three requesters: the video fetcher, the CPU and the boot loader. Each access runs as a fixed-length strobe sequence on the 56 MHz system clock, and the arbiter returns read data through per-requester holding registers. It replaces the two independent memory ports of the machine core with one physical bus.

## Interface
Parameters:
- TACC, 2: number of clocks OE or WE is held active per access (minimum 1).

Ports:
- clock  in  1  56 MHz system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low.
- vReq  in  1  video fetch request, one-clock pulse.
- vA  in  18  video address (bank/page already formed by caller).
- vQ  out  8  video read data, held until the next video read completes.
- vAck  out  1  one-clock pulse when vQ is updated.
- vOvr  out  1  sticky: a vReq arrived while a video request was still pending.
- cReq  in  1  CPU request, level; held until cAck.
- cWr  in  1  1 = write, 0 = read; sampled at grant.
- cA  in  18  CPU address.
- cD  in  8  CPU write data.
- cQ  out  8  CPU read data, held.
- cAck  out  1  one-clock completion pulse.
- lReq  in  1  loader write request, level; held until lAck.
- lA  in  19  loader address (full SRAM space).
- lD  in  8  loader write data.
- lAck  out  1  one-clock completion pulse.
- sramA  out  19  SRAM address.
- sramD  out  8  SRAM write data.
- sramQ  in  8  SRAM read data.
- sramDrive  out  1  1 = FPGA drives the data pins.
- sramOe  out  1  active-low output enable.
- sramWe  out  1  active-low write enable.

## Operation
- Request capture:
  - vReq sets the vPend flag.
  - cReq and lReq are level-sensitive. Each is eligible only while its "served" flag is clear.
  - cServed/lServed set at the requester's ack and clear when the requester deasserts its req. This gives exactly one access per assertion.
- Priority at each grant decision, fixed: video > CPU > loader.
- FSM states:
  - IDLE: grant if anything is eligible, else stay.
  - ADDR: 1 clock. sramA, direction and data are registered from the granted requester. sramDrive=1 for writes.
  - STROBE: TACC clocks. sramOe=0 for reads, sramWe=0 for writes.
  - LATCH: 1 clock. Strobes are released. The granted requester's ack=1. Next state is ADDR if another request is eligible, otherwise IDLE.
- Address mapping:
  - Video and CPU use sramA = {1'b0, addr[17:0]}.
  - Loader uses lA directly.
- Read capture: sramQ is registered into vQ or cQ on the clock edge that leaves the last STROBE cycle. The value is therefore valid in LATCH, coincident with ack.
- Writes:
  - sramD is stable and sramDrive=1 from ADDR through LATCH inclusive.
  - WE rises at least one clock before the address changes.
- A vReq arriving in the same clock that the video request is granted, or in its LATCH, sets a new vPend. It is not lost and does not count as an overrun.
- A vReq arriving while vPend is already set, and that request has not yet been granted, sets vOvr. vPend stays a single request.
- A CPU read or write never updates vQ, and vice versa.

## Timing
- Access length: 2 + TACC clocks. With the default TACC this is 4 clocks (71 ns).
- Back-to-back accesses: LATCH leads directly to ADDR, with no idle clock.
- Latency, request to ack, with no contention:
  - video: 1 (capture) + 4, so vAck arrives 5 clocks after the vReq pulse.
  - CPU/loader: cAck/lAck arrives 5 clocks after req rises.
- Worst-case video latency: one in-flight access plus its own, 2 × 4 + 1 = 9 clocks. The fetcher issues at most one vReq per 8 clocks; this is a budget, not a guarantee. vOvr flags any violation.
- Reset (asynchronous, immediate):
  - State: IDLE.
  - SRAM pins: sramOe=1, sramWe=1, sramDrive=0, sramA=0, sramD=0.
  - Outputs: vAck=cAck=lAck=0, vQ=cQ=8'hFF, vOvr=0.
  - Internal flags: vPend=0, served flags 0.
- Reset mid-access: strobes release in the same instant. A partial write to the addressed byte is accepted. No ack is issued.
- cWr, cA, cD, lA, lD must be stable from req until ack.

## Test plan
- Video read: SRAM 0x14000=0x5A, vReq with vA=0x14000 → sramOe low for exactly 2 clocks; vAck 5 clocks after vReq; vQ=0x5A; cQ unchanged at 0xFF.
- CPU write then read: cReq, cWr=1, cA=0x0C000, cD=0xA5 → sramWe low 2 clocks, sramDrive high 4 clocks, cAck pulse. Drop cReq, then read the same address → cQ=0xA5.
- Simultaneous: vReq and cReq on the same clock → video served first. ADDR for the CPU access follows video LATCH immediately. cAck arrives 9 clocks after request.
- Level-hold: cReq held high for 30 clocks → exactly one access and one cAck. A second access occurs only after cReq deasserts and reasserts.
- Overrun: vReq pulses on two consecutive clocks while a CPU access is in STROBE → vOvr=1 and only one video access is performed. vOvr stays 1 until reset.
- Reset mid-write: reset asserted during STROBE → sramWe=1, sramDrive=0 immediately. No cAck. After release the FSM is IDLE and serves the next cReq normally.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and SRAM pin bundle for ram_arbiter
interface ram_arbiter_if;
  logic        vReq;
  logic [17:0] vA;
  logic [7:0]  vQ;
  logic        vAck;
  logic        vOvr;

  logic        cReq;
  logic        cWr;
  logic [17:0] cA;
  logic [7:0]  cD;
  logic [7:0]  cQ;
  logic        cAck;

  logic        lReq;
  logic [18:0] lA;
  logic [7:0]  lD;
  logic        lAck;

  logic [18:0] sramA;
  logic [7:0]  sramD;
  logic [7:0]  sramQ;
  logic        sramDrive;
  logic        sramOe;
  logic        sramWe;

  modport slave (
    input  vReq, vA, cReq, cWr, cA, cD, lReq, lA, lD, sramQ,
    output vQ, vAck, vOvr, cQ, cAck, lAck, sramA, sramD, sramDrive, sramOe, sramWe
  );

  modport master (
    output vReq, vA, cReq, cWr, cA, cD, lReq, lA, lD, sramQ,
    input  vQ, vAck, vOvr, cQ, cAck, lAck, sramA, sramD, sramDrive, sramOe, sramWe
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port SRAM scheduler for video, CPU and loader requesters
module ram_arbiter #(
  parameter int TACC = 2
) (
  input  logic         clock,
  input  logic         reset,
  ram_arbiter_if.slave bus
);
  localparam int CW = (TACC > 1) ? $clog2(TACC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TACC - 1);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, LATCH} state_t;
  typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_LDR} gnt_t;

  state_t        state;
  gnt_t          gnt;
  logic          wr;
  logic [CW-1:0] cnt;

  logic          v_pend;
  logic [17:0]   v_addr;
  logic          c_req_r;
  logic          l_req_r;
  logic          c_served;
  logic          l_served;

  logic          decide;
  logic          any_elig;
  logic          v_grant;
  gnt_t          next_gnt;
  logic          next_wr;
  logic [18:0]   next_a;
  logic [7:0]    next_d;

  // Fixed-priority pick among eligible requesters, evaluated in IDLE and LATCH
  always_comb begin
    decide   = (state == IDLE) || (state == LATCH);
    any_elig = v_pend || (c_req_r && !c_served) || (l_req_r && !l_served);
    next_gnt = G_NONE;
    next_wr  = 1'b0;
    next_a   = '0;
    next_d   = '0;
    if (v_pend) begin
      next_gnt = G_VID;
      next_a   = {1'b0, v_addr};
    end else if (c_req_r && !c_served) begin
      next_gnt = G_CPU;
      next_wr  = bus.cWr;
      next_a   = {1'b0, bus.cA};
      next_d   = bus.cD;
    end else if (l_req_r && !l_served) begin
      next_gnt = G_LDR;
      next_wr  = 1'b1;
      next_a   = bus.lA;
      next_d   = bus.lD;
    end
    v_grant = decide && v_pend;
  end

  // Request capture, access sequencing and registered SRAM pins / acks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      gnt           <= G_NONE;
      wr            <= 1'b0;
      cnt           <= '0;
      v_pend        <= 1'b0;
      v_addr        <= '0;
      c_req_r       <= 1'b0;
      l_req_r       <= 1'b0;
      c_served      <= 1'b0;
      l_served      <= 1'b0;
      bus.vQ        <= 8'hFF;
      bus.cQ        <= 8'hFF;
      bus.vAck      <= 1'b0;
      bus.cAck      <= 1'b0;
      bus.lAck      <= 1'b0;
      bus.vOvr      <= 1'b0;
      bus.sramA     <= '0;
      bus.sramD     <= '0;
      bus.sramDrive <= 1'b0;
      bus.sramOe    <= 1'b1;
      bus.sramWe    <= 1'b1;
    end else begin
      bus.vAck <= 1'b0;
      bus.cAck <= 1'b0;
      bus.lAck <= 1'b0;
      c_req_r  <= bus.cReq;
      l_req_r  <= bus.lReq;

      // A dropped request re-arms its requester; the ack below takes precedence
      if (!c_req_r) c_served <= 1'b0;
      if (!l_req_r) l_served <= 1'b0;

      // A pulse during the grant clock starts a fresh pending request
      if (bus.vReq) begin
        if (v_pend && !v_grant) begin
          bus.vOvr <= 1'b1;
        end else begin
          v_pend <= 1'b1;
          v_addr <= bus.vA;
        end
      end else if (v_grant) begin
        v_pend <= 1'b0;
      end

      case (state)
        IDLE, LATCH: begin
          if (any_elig) begin
            state         <= ADDR;
            gnt           <= next_gnt;
            wr            <= next_wr;
            bus.sramA     <= next_a;
            bus.sramD     <= next_d;
            bus.sramDrive <= next_wr;
          end else begin
            state         <= IDLE;
            bus.sramDrive <= 1'b0;
          end
        end
        ADDR: begin
          state      <= STROBE;
          cnt        <= '0;
          bus.sramOe <= wr;
          bus.sramWe <= !wr;
        end
        STROBE: begin
          if (cnt == CNT_LAST) begin
            state      <= LATCH;
            bus.sramOe <= 1'b1;
            bus.sramWe <= 1'b1;
            case (gnt)
              G_VID: begin
                bus.vQ   <= bus.sramQ;
                bus.vAck <= 1'b1;
              end
              G_CPU: begin
                if (!wr) bus.cQ <= bus.sramQ;
                bus.cAck <= 1'b1;
                c_served <= 1'b1;
              end
              G_LDR: begin
                bus.lAck <= 1'b1;
                l_served <= 1'b1;
              end
              default: ;
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with SRAM model
module tb_ram_arbiter;
  localparam int TACC = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram_arbiter_if bus ();
  ram_arbiter #(.TACC(TACC)) dut (.clock(clock), .reset(reset), .bus(bus));

  // SRAM contents: initial image plus bytes the DUT has written
  logic [7:0] init_mem [0:524287];
  logic [7:0] wr_mem   [0:524287];
  bit         wr_vld   [0:524287];
  logic [7:0] ref_mem  [0:524287];

  function automatic logic [7:0] sram_rd(input logic [18:0] a);
    return wr_vld[a] ? wr_mem[a] : init_mem[a];
  endfunction

  assign bus.sramQ = bus.sramOe ? 8'h00 : sram_rd(bus.sramA);

  // Asynchronous SRAM: byte stored on each clock the FPGA drives with WE low
  always @(posedge clock) begin
    if (!bus.sramWe && bus.sramDrive) begin
      wr_mem[bus.sramA] <= bus.sramD;
      wr_vld[bus.sramA] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0]  exp_v [$];
  logic [7:0]  exp_c [$];
  logic [18:0] l_addrs [$];
  logic [7:0]  exp_cq = 8'hFF;
  int l_issued = 0;

  int v_acks = 0, c_acks = 0, l_acks = 0;
  int v_ack_cyc = 0, c_ack_cyc = 0, l_ack_cyc = 0;
  int oe_cnt = 0, we_cnt = 0, drv_cnt = 0;
  logic [7:0] last_vq = 8'hFF;
  logic [7:0] last_cq = 8'hFF;

  // Monitor: pops the expected response whenever an ack is presented
  always @(negedge clock) begin
    if (!reset) begin
      last_vq = 8'hFF;
      last_cq = 8'hFF;
    end else begin
      if (!bus.sramOe) oe_cnt++;
      if (!bus.sramWe) we_cnt++;
      if (bus.sramDrive) drv_cnt++;
      if (bus.vAck) begin
        v_acks++;
        v_ack_cyc = cyc;
        if (exp_v.size() == 0) check("vAck_unexpected", 1, 0);
        else begin
          last_vq = exp_v.pop_front();
          check("vQ", bus.vQ, last_vq);
        end
        check("cQ_kept_on_vAck", bus.cQ, last_cq);
      end
      if (bus.cAck) begin
        c_acks++;
        c_ack_cyc = cyc;
        if (exp_c.size() == 0) check("cAck_unexpected", 1, 0);
        else begin
          last_cq = exp_c.pop_front();
          check("cQ", bus.cQ, last_cq);
        end
        check("vQ_kept_on_cAck", bus.vQ, last_vq);
      end
      if (bus.lAck) begin
        l_acks++;
        l_ack_cyc = cyc;
        check("lAck_matches_request", {31'b0, (l_acks <= l_issued)}, 1);
      end
    end
  end

  int v_req_cyc = 0, c_req_cyc = 0, c_base = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic vid_pulse(input logic [17:0] a, input bit expect_access);
    bus.vA   = a;
    bus.vReq = 1'b1;
    if (expect_access) exp_v.push_back(ref_mem[{1'b0, a}]);
    v_req_cyc = cyc;
    tick();
    bus.vReq = 1'b0;
  endtask

  task automatic cpu_start(input logic wr, input logic [17:0] a, input logic [7:0] d);
    bus.cWr = wr;
    bus.cA  = a;
    bus.cD  = d;
    if (wr) ref_mem[{1'b0, a}] = d;
    else exp_cq = ref_mem[{1'b0, a}];
    exp_c.push_back(exp_cq);
    c_base    = c_acks;
    c_req_cyc = cyc;
    bus.cReq  = 1'b1;
  endtask

  task automatic cpu_finish(output int lat);
    for (int i = 0; i < 200 && c_acks == c_base; i++) tick();
    check("cpu_ack_seen", c_acks - c_base, 1);
    lat = c_ack_cyc - c_req_cyc;
    bus.cReq = 1'b0;
    tick();
  endtask

  task automatic ldr_op(input logic [18:0] a, input logic [7:0] d, output int lat);
    int base;
    int start;
    bus.lA     = a;
    bus.lD     = d;
    ref_mem[a] = d;
    l_addrs.push_back(a);
    l_issued++;
    base       = l_acks;
    start      = cyc;
    bus.lReq   = 1'b1;
    for (int i = 0; i < 200 && l_acks == base; i++) tick();
    check("ldr_ack_seen", l_acks - base, 1);
    lat = l_ack_cyc - start;
    bus.lReq = 1'b0;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t, required below 400000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int lat_c;
    int lat_l;
    int n0;
    int o0;
    int w0;
    int d0;
    logic [7:0] b;

    bus.vReq = 1'b0; bus.vA = '0;
    bus.cReq = 1'b0; bus.cWr = 1'b0; bus.cA = '0; bus.cD = '0;
    bus.lReq = 1'b0; bus.lA = '0; bus.lD = '0;
    for (int i = 0; i < 524288; i++) begin
      b = 8'($urandom);
      init_mem[i] = b;
      ref_mem[i]  = b;
    end
    init_mem[19'h14000] = 8'h5A;
    ref_mem[19'h14000]  = 8'h5A;

    #2 reset = 1'b0;
    #1;
    check("rst_sramOe", bus.sramOe, 1);
    check("rst_sramWe", bus.sramWe, 1);
    check("rst_sramDrive", bus.sramDrive, 0);
    check("rst_sramA", bus.sramA, 0);
    check("rst_sramD", bus.sramD, 0);
    check("rst_vQ", bus.vQ, 8'hFF);
    check("rst_cQ", bus.cQ, 8'hFF);
    check("rst_vOvr", bus.vOvr, 0);
    check("rst_acks", {bus.vAck, bus.cAck, bus.lAck}, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Uncontended video read
    o0 = oe_cnt;
    n0 = v_acks;
    vid_pulse(18'h14000, 1'b1);
    for (int i = 0; i < 50 && v_acks == n0; i++) tick();
    check("vid_ack_seen", v_acks - n0, 1);
    check("vid_latency", v_ack_cyc - v_req_cyc, 5);
    check("vid_data", bus.vQ, 8'h5A);
    tick();
    check("vid_oe_clocks", oe_cnt - o0, 2);
    check("vid_cQ_untouched", bus.cQ, 8'hFF);

    // CPU write then read back
    w0 = we_cnt;
    d0 = drv_cnt;
    cpu_start(1'b1, 18'h0C000, 8'hA5);
    cpu_finish(lat);
    check("cpu_wr_latency", lat, 5);
    check("cpu_wr_we_clocks", we_cnt - w0, 2);
    check("cpu_wr_drive_clocks", drv_cnt - d0, 4);
    check("cpu_wr_sram", sram_rd(19'h0C000), 8'hA5);
    cpu_start(1'b0, 18'h0C000, 8'h00);
    cpu_finish(lat);
    check("cpu_rd_latency", lat, 5);
    check("cpu_rd_data", bus.cQ, 8'hA5);

    // Top CPU address stays in the lower half of the SRAM
    cpu_start(1'b1, 18'h3FFFF, 8'h77);
    cpu_finish(lat);
    check("cpu_top_addr", sram_rd(19'h3FFFF), 8'h77);
    check("cpu_top_upper_half", sram_rd(19'h7FFFF), ref_mem[19'h7FFFF]);

    // Video and CPU on the same clock
    cpu_start(1'b0, 18'h0C000, 8'h00);
    vid_pulse(18'h14000, 1'b1);
    cpu_finish(lat);
    check("simul_cpu_latency", lat, 9);
    check("simul_vid_latency", v_ack_cyc - v_req_cyc, 5);

    // Level-held CPU request gives one access per assertion
    n0 = c_acks;
    cpu_start(1'b0, 18'h0C000, 8'h00);
    repeat (30) tick();
    check("level_hold_one_ack", c_acks - n0, 1);
    bus.cReq = 1'b0;
    tick();
    cpu_start(1'b0, 18'h0C000, 8'h00);
    cpu_finish(lat);
    check("level_reassert_latency", lat, 5);
    check("level_reassert_two_acks", c_acks - n0, 2);

    // Loader write at the last SRAM byte
    ldr_op(19'h7FFFF, 8'hC3, lat);
    check("ldr_latency", lat, 5);
    check("ldr_top_write", sram_rd(19'h7FFFF), 8'hC3);

    // Randomised traffic from all three requesters
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          vid_pulse(18'($urandom_range(0, 32'h0FFFF)), 1'b1);
          repeat ($urandom_range(10, 20)) tick();
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          cpu_start(1'($urandom), 18'h10000 + 18'($urandom_range(0, 255)), 8'($urandom));
          cpu_finish(lat_c);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          ldr_op(19'h40000 + 19'($urandom_range(0, 4095)), 8'($urandom), lat_l);
          repeat ($urandom_range(0, 5)) tick();
        end
      end
    join
    repeat (30) tick();
    check("rand_vid_drained", exp_v.size(), 0);
    check("rand_cpu_drained", exp_c.size(), 0);
    check("rand_ldr_acks", l_acks, l_issued);
    check("rand_no_overrun", bus.vOvr, 0);
    while (l_addrs.size() > 0) begin
      logic [18:0] a;
      a = l_addrs.pop_front();
      check("ldr_sram_byte", sram_rd(a), ref_mem[a]);
    end

    // Two video pulses while a CPU access is strobing
    n0 = v_acks;
    cpu_start(1'b0, 18'h10000, 8'h00);
    repeat (3) tick();
    vid_pulse(18'h14000, 1'b1);
    vid_pulse(18'h14000, 1'b0);
    cpu_finish(lat);
    repeat (20) tick();
    check("ovr_single_access", v_acks - n0, 1);
    check("ovr_flag", bus.vOvr, 1);
    repeat (10) tick();
    check("ovr_sticky", bus.vOvr, 1);

    // Reset in the middle of a CPU write
    cpu_start(1'b1, 18'h10080, 8'h3C);
    repeat (3) tick();
    check("midwr_we_low", bus.sramWe, 0);
    n0 = c_acks;
    reset = 1'b0;
    #1;
    check("midwr_we_released", bus.sramWe, 1);
    check("midwr_drive_released", bus.sramDrive, 0);
    check("midwr_oe_idle", bus.sramOe, 1);
    bus.cReq = 1'b0;
    void'(exp_c.pop_back());
    exp_cq = 8'hFF;
    repeat (4) tick();
    check("midwr_no_ack", c_acks - n0, 0);
    check("midwr_vOvr_cleared", bus.vOvr, 0);
    check("midwr_cQ_reset", bus.cQ, 8'hFF);
    check("midwr_vQ_reset", bus.vQ, 8'hFF);
    check("midwr_sramA_reset", bus.sramA, 0);
    reset = 1'b1;
    repeat (2) tick();
    cpu_start(1'b0, 18'h10000, 8'h00);
    cpu_finish(lat);
    check("post_reset_latency", lat, 5);
    repeat (5) tick();
    check("final_queues_empty", exp_v.size() + exp_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
